// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller:
//   - REG_IDX_W            : register index width (R0..R15)
//   - MEM_WAIT_CYCLES_DEF  : default number of freeze cycles per MEM access
//   - wait_state_e         : SRAM wait-state FSM encoding (IDLE / WAIT)
// ----------------------------------------------------------------------------
package pipe_pkg;

   localparam int REG_IDX_W           = 4;
   localparam int MEM_WAIT_CYCLES_DEF = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wait_state_e;

endpackage : pipe_pkg

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purely combinational RAW hazard detector for the instruction in ID.
// Build option: FORWARDING_EN
//   undefined : stall on any valid source matching a pending write in EXE or MEM
//   defined   : stall only on load-use (load in EXE writing a valid source);
//               MEM-stage matches are covered by the forwarding unit.
// Ports:
//   id_src1_i / id_src2_i            source register indices of the ID instruction
//   id_src1_valid_i / id_src2_valid_i  source actually read
//   exe_dest_i, exe_wb_en_i, exe_mem_r_en_i  destination info held in ID/EXE
//   mem_dest_i, mem_wb_en_i          destination info held in EXE/MEM
//   hazard_o                         ID instruction must wait
// ----------------------------------------------------------------------------
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_src1_i,
   input  logic [REG_IDX_W-1:0] id_src2_i,
   input  logic                 id_src1_valid_i,
   input  logic                 id_src2_valid_i,
   input  logic [REG_IDX_W-1:0] exe_dest_i,
   input  logic                 exe_wb_en_i,
   input  logic                 exe_mem_r_en_i,
   input  logic [REG_IDX_W-1:0] mem_dest_i,
   input  logic                 mem_wb_en_i,
   output logic                 hazard_o
);

   logic exe_match;
   logic mem_match;

   // R15 is compared like any other register.
   assign exe_match = exe_wb_en_i &
                      ((id_src1_valid_i & (id_src1_i == exe_dest_i)) |
                       (id_src2_valid_i & (id_src2_i == exe_dest_i)));

   assign mem_match = mem_wb_en_i &
                      ((id_src1_valid_i & (id_src1_i == mem_dest_i)) |
                       (id_src2_valid_i & (id_src2_i == mem_dest_i)));

`ifdef FORWARDING_EN
   // Only a load in EXE cannot be forwarded in time.
   assign hazard_o = exe_mem_r_en_i & exe_match;

   logic unused_mem_match;
   assign unused_mem_match = mem_match;
`else
   assign hazard_o = exe_match | mem_match;

   logic unused_exe_mem_r_en;
   assign unused_exe_mem_r_en = exe_mem_r_en_i;
`endif

endmodule : hazard_detect

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central freeze/flush sequencer for the 5-stage pipeline. Combines the SRAM
// wait-state FSM, taken-branch flush and RAW hazard stall (priority in that
// order) and keeps a saturating count of cycles with freeze_pc asserted.
// Build option: FORWARDING_EN (see hazard_detect) selects load-use-only stalls.
// Parameters:
//   MEM_WAIT_CYCLES : freeze cycles per MEM data access (0 = never freeze)
//   CNT_W           : width of stall_count
// Ports:
//   clk, rst (synchronous, active high)
//   id_*            : source operands of the ID instruction
//   exe_*, mem_*    : destination info held in ID/EXE and EXE/MEM
//   mem_req         : MEM stage holds a load/store
//   exe_branch_taken: EXE resolves a taken branch
//   freeze_pc/exe/mem, flush_if/id : pipeline register controls
//   mem_busy        : wait FSM is holding the pipeline
//   stall_count     : saturating count of freeze_pc cycles
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF,
   parameter int CNT_W           = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] id_src1,
   input  logic [REG_IDX_W-1:0] id_src2,
   input  logic                 id_src1_valid,
   input  logic                 id_src2_valid,
   input  logic [REG_IDX_W-1:0] exe_dest,
   input  logic                 exe_wb_en,
   input  logic                 exe_mem_r_en,
   input  logic [REG_IDX_W-1:0] mem_dest,
   input  logic                 mem_wb_en,
   input  logic                 mem_req,
   input  logic                 exe_branch_taken,
   output logic                 freeze_pc,
   output logic                 freeze_exe,
   output logic                 freeze_mem,
   output logic                 flush_if,
   output logic                 flush_id,
   output logic                 mem_busy,
   output logic [CNT_W-1:0]     stall_count
);

   // Counter only ever holds values up to MEM_WAIT_CYCLES-1.
   localparam int WCNT_W = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
   localparam logic [WCNT_W-1:0] WAIT_INIT =
      (MEM_WAIT_CYCLES > 0) ? WCNT_W'(MEM_WAIT_CYCLES - 1) : '0;

   wait_state_e       state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              busy;
   logic              hazard;

   hazard_detect u_hazard_detect (
      .id_src1_i       (id_src1),
      .id_src2_i       (id_src2),
      .id_src1_valid_i (id_src1_valid),
      .id_src2_valid_i (id_src2_valid),
      .exe_dest_i      (exe_dest),
      .exe_wb_en_i     (exe_wb_en),
      .exe_mem_r_en_i  (exe_mem_r_en),
      .mem_dest_i      (mem_dest),
      .mem_wb_en_i     (mem_wb_en),
      .hazard_o        (hazard)
   );

   // Wait-state FSM: next state and busy indication.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned (which would infer a latch).
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      busy       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (mem_req && (MEM_WAIT_CYCLES > 0)) begin
               busy       = 1'b1;
               state_d    = ST_WAIT;
               wait_cnt_d = WAIT_INIT;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q != '0) begin
               busy       = 1'b1;
               wait_cnt_d = wait_cnt_q - 1'b1;
            end else begin
               // Access retires this cycle; mem_req still shows it, so ignore.
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Priority mux: memory freeze > branch flush > hazard stall.
   always_comb begin
      freeze_pc  = 1'b0;
      freeze_exe = 1'b0;
      freeze_mem = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
      mem_busy   = 1'b0;
      if (!rst) begin
         if (busy) begin
            // Branch/hazard stay asserted by their sources and are handled
            // on the first unfrozen cycle.
            mem_busy   = 1'b1;
            freeze_pc  = 1'b1;
            freeze_exe = 1'b1;
            freeze_mem = 1'b1;
         end else if (exe_branch_taken) begin
            // ID instruction is squashed, so its hazard is irrelevant.
            flush_if = 1'b1;
            flush_id = 1'b1;
         end else if (hazard) begin
            freeze_pc = 1'b1;
            flush_id  = 1'b1;
         end
      end
   end

   assign stall_cnt_d = (freeze_pc && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1
                                                           : stall_cnt_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl (MEM_WAIT_CYCLES=2, CNT_W=4).
// Each step drives inputs after a falling edge, pushes the expected control
// vector and stall count to a scoreboard queue, then pops and compares once
// the combinational outputs have settled, before the next rising edge.
// Expectations for FORWARDING_EN-dependent cases follow the same macro.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

   // {mem_busy, freeze_pc, freeze_exe, freeze_mem, flush_if, flush_id}
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_BUSY = 6'b111100;
   localparam logic [5:0] C_BR   = 6'b000011;
   localparam logic [5:0] C_HZ   = 6'b010001;
`ifdef FORWARDING_EN
   localparam logic [5:0] C_HZ_NOFWD = C_NONE;
`else
   localparam logic [5:0] C_HZ_NOFWD = C_HZ;
`endif

   typedef struct {
      logic [5:0] ctl;
      logic [3:0] cnt;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       id_src1_valid, id_src2_valid;
   logic       exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, exe_branch_taken;
   logic       freeze_pc, freeze_exe, freeze_mem, flush_if, flush_id, mem_busy;
   logic [3:0] stall_count;

   exp_t       sb[$];
   logic [3:0] exp_cnt = 4'd0;
   int         checks  = 0;
   int         errors  = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .MEM_WAIT_CYCLES (2),
      .CNT_W           (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .id_src1          (id_src1),
      .id_src2          (id_src2),
      .id_src1_valid    (id_src1_valid),
      .id_src2_valid    (id_src2_valid),
      .exe_dest         (exe_dest),
      .exe_wb_en        (exe_wb_en),
      .exe_mem_r_en     (exe_mem_r_en),
      .mem_dest         (mem_dest),
      .mem_wb_en        (mem_wb_en),
      .mem_req          (mem_req),
      .exe_branch_taken (exe_branch_taken),
      .freeze_pc        (freeze_pc),
      .freeze_exe       (freeze_exe),
      .freeze_mem       (freeze_mem),
      .flush_if         (flush_if),
      .flush_id         (flush_id),
      .mem_busy         (mem_busy),
      .stall_count      (stall_count)
   );

   task automatic clear_inputs();
      id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
      id_src1_valid = 1'b0; id_src2_valid = 1'b0;
      exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
      mem_req = 1'b0; exe_branch_taken = 1'b0;
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic step(input logic [5:0] ctl, input string tag);
      exp_t       e;
      logic [5:0] obs;
      e.ctl = ctl;
      e.cnt = exp_cnt;
      e.tag = tag;
      sb.push_back(e);
      #2;
      e   = sb.pop_front();
      obs = {mem_busy, freeze_pc, freeze_exe, freeze_mem, flush_if, flush_id};
      checks++;
      assert (obs === e.ctl) else begin
         errors++;
         $error("FAIL %s ctl: got %b expected %b", e.tag, obs, e.ctl);
      end
      checks++;
      assert (stall_count === e.cnt) else begin
         errors++;
         $error("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, e.cnt);
      end
      // Counter effect of the coming rising edge.
      if (rst)                            exp_cnt = 4'd0;
      else if (ctl[4] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      rst     = 1'b1;
      mem_req = 1'b1;
      @(negedge clk);

      // Reset held with mem_req asserted: everything forced low.
      step(C_NONE, "rst0");
      step(C_NONE, "rst1");

      // Memory wait: three cycles of mem_req -> 1,1,0; new access pays again.
      rst = 1'b0;
      step(C_BUSY, "mem_a0");
      step(C_BUSY, "mem_a1");
      step(C_NONE, "mem_a_retire");
      step(C_BUSY, "mem_b0");
      mem_req = 1'b0;
      step(C_BUSY, "mem_b1");
      step(C_NONE, "mem_b_retire");
      step(C_NONE, "idle");

      // Branch beats a concurrent EXE hazard.
      id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
      exe_branch_taken = 1'b1;
      step(C_BR, "branch_over_hazard");
      exe_branch_taken = 1'b0;
      step(C_HZ_NOFWD, "exe_raw_alu");

      // RAW against MEM stage on src2.
      clear_inputs();
      id_src2 = 4'd5; id_src2_valid = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1;
      step(C_HZ_NOFWD, "mem_raw_src2");
      clear_inputs();
      step(C_NONE, "after_mem_raw");

      // Load-use: stalls in both builds.
      exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd7;
      id_src1 = 4'd7; id_src1_valid = 1'b1;
      step(C_HZ, "load_use");
      exe_mem_r_en = 1'b0;
      step(C_HZ_NOFWD, "alu_use");
      exe_mem_r_en = 1'b1; id_src1_valid = 1'b0;
      step(C_NONE, "src_not_valid");
      id_src2 = 4'd7; id_src2_valid = 1'b1;
      step(C_HZ, "load_use_src2");
      exe_wb_en = 1'b0;
      step(C_NONE, "no_wb_en");

      // Hold a load-use hazard for 20 cycles: counter saturates at 15.
      exe_wb_en = 1'b1;
      for (int i = 0; i < 20; i++) step(C_HZ, $sformatf("sat%0d", i));
      clear_inputs();
      step(C_NONE, "sat_hold");

      // Branch during a memory freeze is deferred to the unfrozen cycle.
      mem_req = 1'b1; exe_branch_taken = 1'b1;
      step(C_BUSY, "br_in_freeze0");
      mem_req = 1'b0;
      step(C_BUSY, "br_in_freeze1");
      step(C_BR, "br_after_freeze");
      clear_inputs();
      step(C_NONE, "br_done");

      // Memory freeze outranks a hazard.
      mem_req = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd9;
      id_src1 = 4'd9; id_src1_valid = 1'b1;
      step(C_BUSY, "busy_over_hazard");
      clear_inputs();
      step(C_BUSY, "busy_over_hazard1");
      step(C_NONE, "busy_over_hazard_done");

      // Reset in the middle of WAIT: back to IDLE, no lingering freeze.
      mem_req = 1'b1;
      step(C_BUSY, "midwait0");
      rst = 1'b1;
      step(C_NONE, "midwait_rst");
      rst = 1'b0; mem_req = 1'b0;
      step(C_NONE, "midwait_after");
      step(C_NONE, "midwait_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage ARM pipeline registers (IF, ID/EXE, EXE/MEM, MEM/WB).
- Generates hold (freeze) and bubble (flush) controls for the pipeline from three sources: the SRAM wait-state FSM, taken-branch flush, and RAW hazard detection.
- Sits beside the ID stage.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MEM_WAIT_CYCLES, 2: freeze cycles per MEM-stage data access. 0 means no freeze.
- CNT_W, 16: width of stall_count.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- id_src1  input  4  Rn index of the instruction in ID
- id_src2  input  4  Rm (or Rd for STR) index of the instruction in ID
- id_src1_valid  input  1  ID instruction reads src1
- id_src2_valid  input  1  ID instruction reads src2
- exe_dest  input  4  Dest held in the ID/EXE register
- exe_wb_en  input  1  WB_EN held in the ID/EXE register
- exe_mem_r_en  input  1  MEM_R_EN held in the ID/EXE register (load in EXE)
- mem_dest  input  4  Dest held in the EXE/MEM register
- mem_wb_en  input  1  WB_EN held in the EXE/MEM register
- mem_req  input  1  MEM stage holds a load or store (MEM_R_EN | MEM_W_EN)
- exe_branch_taken  input  1  EXE stage resolves a taken branch
- freeze_pc  output  1  hold PC and the IF/ID register
- freeze_exe  output  1  hold the ID/EXE register
- freeze_mem  output  1  hold the EXE/MEM and MEM/WB registers
- flush_if  output  1  bubble into the IF/ID register
- flush_id  output  1  bubble into the ID/EXE register (drives its flush)
- mem_busy  output  1  the wait FSM is holding the pipeline
- stall_count  output  CNT_W  saturating count of cycles with freeze_pc=1

Behaviour:
- Reset:
  - Synchronous. On the next edge: state=IDLE, wait_cnt=0, stall_count=0.
  - All control outputs are combinational from state and inputs. While rst=1 they are forced to 0.
- FSM states: IDLE, WAIT.
  - IDLE & mem_req & MEM_WAIT_CYCLES>0: mem_busy=1. Next state WAIT, wait_cnt=MEM_WAIT_CYCLES-1.
  - WAIT & wait_cnt!=0: mem_busy=1, wait_cnt decrements.
  - WAIT & wait_cnt==0: mem_busy=0. mem_req is ignored this cycle, because the same access is retiring. Next state IDLE.
  - Result: exactly MEM_WAIT_CYCLES frozen cycles per access. Back-to-back accesses each pay the full wait.
- mem_busy=1:
  - freeze_pc, freeze_exe and freeze_mem all =1.
  - flush_if and flush_id =0. A branch or hazard present during the freeze is acted on the first unfrozen cycle, since it is still present.
- Otherwise (mem_busy=0), in priority order:
  - branch: exe_branch_taken → flush_if=1, flush_id=1. Hazard stall is suppressed, because the ID instruction is squashed.
  - hazard (below) → freeze_pc=1, flush_id=1 (bubble), freeze_exe=0, freeze_mem=0.
  - else all outputs 0.
- Hazard (no forwarding):
  - (id_src1_valid & exe_wb_en & id_src1==exe_dest), OR the same check for src2, OR the same two checks against mem_wb_en/mem_dest.
  - R15 is not special-cased.
- stall_count increments on each clock where freeze_pc=1. It saturates at all-ones; it does not wrap.
- rst mid-WAIT: returns to IDLE and the freeze drops on the following cycle.

Optional Feature:
- FORWARDING_EN defined:
  - Hazard = load-use only: exe_mem_r_en & exe_wb_en & a valid src matching exe_dest.
  - MEM-stage matches are ignored, because the forwarding unit covers them.
- FORWARDING_EN undefined: full hazard rule as above.

Decomposition:
- Shared package pipe_pkg:
  - FSM state typedef (IDLE/WAIT).
  - REG_IDX_W=4.
  - Default MEM_WAIT_CYCLES constant.
- One natural sub-module: hazard_detect. It is combinational and holds the src/dest compare plus the FORWARDING_EN logic.
- The FSM, priority mux and counter stay at top level.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_req=1 → all outputs 0, stall_count=0; state IDLE after release.
- Memory wait (MEM_WAIT_CYCLES=2): mem_req=1 for 3 cycles → mem_busy/freeze_* =1,1,0 across those cycles. A new mem_req on cycle 4 → freeze again for 2 cycles.
- Branch: exe_branch_taken=1 with a concurrent hazard (id_src1=3, exe_dest=3, exe_wb_en=1) → flush_if=1, flush_id=1, freeze_pc=0 for that cycle.
- RAW without forwarding: id_src2=5 valid, mem_dest=5, mem_wb_en=1 → freeze_pc=1, flush_id=1, stall_count increments by 1. The same case with FORWARDING_EN → no stall.
- Load-use with FORWARDING_EN: exe_mem_r_en=1, exe_wb_en=1, exe_dest=7, id_src1=7 → one-cycle stall. With exe_mem_r_en=0 → no stall.
- Saturation (CNT_W=4): hold the hazard for 20 cycles → stall_count stops at 15. A branch arriving during a memory freeze → flush deferred until the cycle mem_busy drops.
